// File: rtl/pir_motion_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pir_motion_conditioner
// Description : Synchronises and debounces the raw PIR line on JA1, then
//               stretches each detection with a retriggerable hold time.
//               Emits a motion level, a per-event strobe and a saturating
//               event count.
// Revision    : 1.0 - initial release
// ============================================================================
module pir_motion_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 200_000_000,
  parameter int COUNT_W         = 14,
  parameter int COUNT_MAX       = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               JA1,
  input  logic               enable,
  input  logic               clear_count,
  output logic               motion_detected,
  output logic               motion_pulse,
  output logic [COUNT_W-1:0] event_count,
  output logic [1:0]         state
);

  localparam int C_DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [C_DEB_W-1:0]  C_DEB_LAST  = C_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [COUNT_W-1:0]  C_COUNT_MAX = COUNT_W'(COUNT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic                r_sync1;
  logic                r_sync2;
  logic                r_deb;
  logic [C_DEB_W-1:0]  r_deb_cnt;
  state_t              r_state;
  state_t              w_next_state;
  logic [C_HOLD_W-1:0] r_hold_cnt;
  logic [C_HOLD_W-1:0] w_hold_next;
  logic                w_new_event;
  logic                r_motion;
  logic                r_pulse;
  logic [COUNT_W-1:0]  r_count;

  // Two-flop synchroniser; r_sync2 is the only consumer-visible copy of JA1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= JA1;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == C_DEB_LAST) begin
      r_deb     <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_hold_next  = r_hold_cnt;
    w_new_event  = 1'b0;
    if (!enable) begin
      w_next_state = ST_IDLE;
      w_hold_next  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_deb) begin
            w_next_state = ST_ACTIVE;
            w_new_event  = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!r_deb) begin
            w_next_state = ST_HOLD;
            w_hold_next  = '0;
          end
        end
        ST_HOLD: begin
          // A rising deb on the final hold cycle retriggers rather than expiring
          if (r_deb) begin
            w_next_state = ST_ACTIVE;
          end else if (r_hold_cnt == C_HOLD_LAST) begin
            w_next_state = ST_IDLE;
            w_hold_next  = '0;
          end else begin
            w_hold_next = r_hold_cnt + 1'b1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_hold_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_motion   <= 1'b0;
      r_pulse    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_hold_cnt <= w_hold_next;
      r_motion   <= (w_next_state != ST_IDLE);
      r_pulse    <= w_new_event;
      if (clear_count) begin
        r_count <= '0;
      end else if (w_new_event && (r_count != C_COUNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign motion_detected = r_motion;
  assign motion_pulse    = r_pulse;
  assign event_count     = r_count;
  assign state           = r_state;

endmodule
`default_nettype wire
